// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// irq_ctrl_pkg : shared special-register map and interrupt controller types
// Revision     : 1.0
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

  // Special-register address map on the execute-stage sr_bus
  localparam int SREG_PC        = 0;
  localparam int SREG_SP        = 1;
  localparam int SREG_LR        = 2;
  localparam int SREG_STATUS    = 3;
  localparam int SREG_ALU_FLAGS = 4;
  localparam int SREG_IRQ_MASK  = 5;
  localparam int SREG_IRQ_PEND  = 6;
  localparam int SREG_IRQ_CAUSE = 7;

  // Bit position of the valid flag inside IRQ_CAUSE (MSB of a 16-bit register)
  localparam int IRQ_CAUSE_VALID = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// irq_prio_enc : lowest-index-first priority encoder, returns {any, index}
// Revision     : 1.0
// ============================================================================
`default_nettype none

module irq_prio_enc #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_req,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    // Walk downward so the lowest set index is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// irq_ctrl : pending/mask/priority interrupt controller driving execute i_irq
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int               N_SRC     = 8,
  parameter int               RW        = 16,
  parameter logic [N_SRC-1:0] EDGE_MASK = 8'hFF,
  parameter int               SREG_BASE = SREG_IRQ_MASK
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_src,
  output logic             o_irq,
  input  logic             i_irq_ack,
  input  logic [RW-1:0]    i_sr_addr,
  input  logic [RW-1:0]    i_sr_data,
  input  logic             i_sr_we,
  output logic [RW-1:0]    o_sr_data,
  output logic             o_sr_hit
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] src_q, src_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [RW-1:0]    cause_q, cause_d;
  irq_state_e       state_q, state_d;

  logic             w_sel_mask, w_sel_pend, w_sel_cause;
  logic [N_SRC-1:0] w_eligible, w_set, w_clr;
  logic             w_win_any;
  logic [IW-1:0]    w_win_idx;

  assign w_sel_mask  = (i_sr_addr == RW'(SREG_BASE));
  assign w_sel_pend  = (i_sr_addr == RW'(SREG_BASE + 1));
  assign w_sel_cause = (i_sr_addr == RW'(SREG_BASE + 2));
  assign w_eligible  = pend_q & mask_q;

  irq_prio_enc #(
    .N  (N_SRC),
    .IW (IW)
  ) u_prio (
    .i_req (w_eligible),
    .o_any (w_win_any),
    .o_idx (w_win_idx)
  );

  always_comb begin
    src_d   = i_src;
    mask_d  = mask_q;
    cause_d = cause_q;
    state_d = state_q;
    w_set   = (i_src & ~src_q & EDGE_MASK) | (i_src & ~EDGE_MASK);
    w_clr   = '0;

    if (i_sr_we && w_sel_mask) mask_d = i_sr_data[N_SRC-1:0];
    if (i_sr_we && w_sel_pend) w_clr  = i_sr_data[N_SRC-1:0];

    case (state_q)
      ST_IDLE: begin
        if (w_win_any) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (i_irq_ack) begin
          // An ack with nothing eligible is spurious: cause reports valid, index 0
          state_d                  = ST_SERVICE;
          cause_d                  = '0;
          cause_d[RW-1]            = 1'b1;
          if (w_win_any) begin
            cause_d[IW-1:0]        = w_win_idx;
            w_clr[w_win_idx]       = w_clr[w_win_idx] | EDGE_MASK[w_win_idx];
          end
        end else if (!w_win_any) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (i_sr_we && w_sel_cause) begin
          cause_d[RW-1] = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // New captures take precedence over software / ack clears
    pend_d = (pend_q & ~w_clr) | w_set;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      cause_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      src_q   <= src_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      cause_q <= cause_d;
      state_q <= state_d;
    end
  end

  assign o_irq    = (state_q == ST_REQ);
  assign o_sr_hit = w_sel_mask | w_sel_pend | w_sel_cause;

  always_comb begin
    o_sr_data = '0;
    if (w_sel_mask)  o_sr_data[N_SRC-1:0] = mask_q;
    if (w_sel_pend)  o_sr_data[N_SRC-1:0] = pend_q;
    if (w_sel_cause) o_sr_data            = cause_q;
  end

endmodule

`default_nettype wire
